// File: rtl/cpu_trace_fifo.sv
// cpu_trace_fifo: captures one {pc, instruction, alu_out, mem_data} sample per
// clock while armed, into a circular FIFO drained through a registered pop port.
// Capture ends on a stop pulse or when the cpu executes HALT_INSN; samples that
// arrive while the FIFO is full are counted in a saturating dropped counter.
module cpu_trace_fifo #(
  parameter int          DEPTH     = 16,
  parameter int          ADDR_W    = 4,
  parameter logic [31:0] HALT_INSN = 32'hD4400000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [63:0]       pc,
  input  logic [31:0]       instruction,
  input  logic [63:0]       alu_out,
  input  logic [63:0]       mem_data,
  input  logic              pop,
  output logic              rd_valid,
  output logic [63:0]       rd_pc,
  output logic [31:0]       rd_instr,
  output logic [63:0]       rd_alu,
  output logic [63:0]       rd_mem,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic [15:0]       dropped,
  output logic              halted,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    DONE    = 2'b10
  } state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] alu;
    logic [63:0] mem;
  } trace_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t            st;
  trace_t            mem_q [DEPTH];
  trace_t            sample;
  trace_t            rd_q;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   cnt;

  logic capture_now;
  logic halt_hit;
  logic pop_ok;
  logic push_ok;
  logic drop;
  logic arm;

  assign sample = '{pc: pc, instr: instruction, alu: alu_out, mem: mem_data};

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign state = st;

  assign rd_pc    = rd_q.pc;
  assign rd_instr = rd_q.instr;
  assign rd_alu   = rd_q.alu;
  assign rd_mem   = rd_q.mem;

  // A stop pulse suppresses the sample of its own cycle, and beats a halt.
  assign capture_now = (st == CAPTURE) && !stop;
  assign halt_hit    = capture_now && (instruction == HALT_INSN);
  // Pop on an empty FIFO is ignored even if a push lands in the same cycle.
  assign pop_ok      = pop && !empty;
  // When full, a same-cycle pop frees the slot the push reuses.
  assign push_ok     = capture_now && (!full || pop_ok);
  assign drop        = capture_now && full && !pop_ok;
  assign arm         = start && (st != CAPTURE);

  // Capture FSM with halt flag and saturating drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      st      <= IDLE;
      halted  <= 1'b0;
      dropped <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (start) st <= CAPTURE;
        end
        CAPTURE: begin
          if (stop) begin
            st <= DONE;
          end else if (halt_hit) begin
            st     <= DONE;
            halted <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            st     <= CAPTURE;
            halted <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase

      // Re-arming starts a fresh loss tally; drops only occur in CAPTURE.
      if (arm)
        dropped <= '0;
      else if (drop && (dropped != 16'hFFFF))
        dropped <= dropped + 16'd1;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + ADDR_W'(1);
      if (pop_ok)  rptr <= rptr + ADDR_W'(1);
      if (push_ok && !pop_ok)
        cnt <= cnt + (ADDR_W+1)'(1);
      else if (pop_ok && !push_ok)
        cnt <= cnt - (ADDR_W+1)'(1);
    end
  end

  // Trace storage, deliberately not reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wptr] <= sample;
  end

  // Registered read port; the old entry is read even if a full-FIFO push
  // overwrites the same slot on this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_q     <= '0;
    end else begin
      rd_valid <= pop_ok;
      if (pop_ok) rd_q <= mem_q[rptr];
    end
  end

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// Directed bench for cpu_trace_fifo: capture/drain, overflow, full push+pop,
// halt, pointer wrap, stop-vs-halt, empty pop and mid-capture reset.
module tb_cpu_trace_fifo;

  localparam logic [31:0] HALT = 32'hD4400000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [63:0] pc = '0;
  logic [31:0] instruction = '0;
  logic [63:0] alu_out = '0;
  logic [63:0] mem_data = '0;
  logic        pop = 1'b0;
  logic        rd_valid;
  logic [63:0] rd_pc;
  logic [31:0] rd_instr;
  logic [63:0] rd_alu;
  logic [63:0] rd_mem;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic [15:0] dropped;
  logic        halted;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;

  cpu_trace_fifo #(.DEPTH(16), .ADDR_W(4), .HALT_INSN(HALT)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .pc(pc), .instruction(instruction), .alu_out(alu_out), .mem_data(mem_data),
    .pop(pop), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_alu(rd_alu), .rd_mem(rd_mem), .count(count), .empty(empty),
    .full(full), .dropped(dropped), .halted(halted), .state(state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cpu cycle; alu/mem are derived from pc so their capture is checkable.
  task automatic drive(input logic [63:0] p, input logic [31:0] ins);
    pc          = p;
    instruction = ins;
    alu_out     = p ^ 64'hA5;
    mem_data    = p + 64'h1000;
    tick();
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] exp_pc);
    pop = 1'b1;
    tick();
    chk({tag, "_valid"}, {63'd0, rd_valid}, 64'd1);
    chk({tag, "_pc"}, rd_pc, exp_pc);
  endtask

  initial begin
    // ---- reset state
    tick();
    reset = 1'b0;
    chk("rst_count", {59'd0, count}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_pc", rd_pc, 64'd0);
    chk("rst_dropped", {48'd0, dropped}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_state", {62'd0, state}, 64'd0);

    // ---- basic capture of five samples
    start = 1'b1;
    drive(64'd999, 32'd0);
    start = 1'b0;
    chk("arm_state", {62'd0, state}, 64'd1);
    chk("arm_nocap", {59'd0, count}, 64'd0);
    for (int i = 0; i < 5; i++) drive(64'(4 * i), 32'(i + 1));
    stop = 1'b1;
    drive(64'd777, 32'd0);
    stop = 1'b0;
    chk("t1_count", {59'd0, count}, 64'd5);
    chk("t1_state", {62'd0, state}, 64'd2);
    for (int i = 0; i < 5; i++) begin
      pop_chk("t1_pop", 64'(4 * i));
      chk("t1_instr", {32'd0, rd_instr}, 64'(i + 1));
      chk("t1_alu", rd_alu, 64'(4 * i) ^ 64'hA5);
      chk("t1_mem", rd_mem, 64'(4 * i) + 64'h1000);
      pop = 1'b0;
      tick();
      chk("t1_gap_valid", {63'd0, rd_valid}, 64'd0);
      chk("t1_gap_hold", rd_pc, 64'(4 * i));
    end
    chk("t1_empty", {63'd0, empty}, 64'd1);

    // ---- overflow: 19 samples into 16 slots
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 19; i++) drive(64'(4 * i), 32'd0);
    chk("t2_full", {63'd0, full}, 64'd1);
    chk("t2_count", {59'd0, count}, 64'd16);
    chk("t2_dropped", {48'd0, dropped}, 64'd3);

    // ---- full with simultaneous pop and push (pc=100)
    pop = 1'b1;
    drive(64'd100, 32'd0);
    chk("t3_first_pc", rd_pc, 64'd0);
    chk("t3_first_valid", {63'd0, rd_valid}, 64'd1);
    chk("t3_count", {59'd0, count}, 64'd16);
    chk("t3_dropped", {48'd0, dropped}, 64'd3);
    pop = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_stop_count", {59'd0, count}, 64'd16);
    for (int i = 1; i < 16; i++) pop_chk("t3_drain", 64'(4 * i));
    pop_chk("t3_last", 64'd100);
    pop = 1'b0;
    tick();
    chk("t3_empty_count", {59'd0, count}, 64'd0);

    // ---- halt on third sample
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(64'd200, 32'd0);
    drive(64'd204, 32'd0);
    drive(64'd208, HALT);
    chk("t4_count", {59'd0, count}, 64'd3);
    chk("t4_halted", {63'd0, halted}, 64'd1);
    chk("t4_state", {62'd0, state}, 64'd2);
    drive(64'd212, 32'd0);
    chk("t4_after_count", {59'd0, count}, 64'd3);
    pop_chk("t4_pop", 64'd200);
    pop_chk("t4_pop", 64'd204);
    pop_chk("t4_pop", 64'd208);
    chk("t4_pop_instr", {32'd0, rd_instr}, {32'd0, HALT});
    pop = 1'b0;

    // ---- pointer wrap: capture 12, pop 10, capture 10
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_halt_clr", {63'd0, halted}, 64'd0);
    for (int i = 0; i < 12; i++) drive(64'(1000 + 4 * i), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 10; i++) pop_chk("t5_pop1", 64'(1000 + 4 * i));
    pop = 1'b0;
    chk("t5_mid_count", {59'd0, count}, 64'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) drive(64'(2000 + 4 * i), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5_count", {59'd0, count}, 64'd12);
    pop_chk("t5_old", 64'd1040);
    pop_chk("t5_old", 64'd1044);
    for (int i = 0; i < 10; i++) pop_chk("t5_new", 64'(2000 + 4 * i));
    pop = 1'b0;
    tick();
    chk("t5_empty", {63'd0, empty}, 64'd1);

    // ---- stop and halt together: stop wins
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b1;
    drive(64'd5000, HALT);
    stop = 1'b0;
    chk("t6_sh_state", {62'd0, state}, 64'd2);
    chk("t6_sh_halted", {63'd0, halted}, 64'd0);
    chk("t6_sh_count", {59'd0, count}, 64'd0);

    // ---- pop while empty
    pop = 1'b1;
    drive(64'd0, 32'd0);
    pop = 1'b0;
    chk("t6_epop_valid", {63'd0, rd_valid}, 64'd0);
    chk("t6_epop_count", {59'd0, count}, 64'd0);
    chk("t6_epop_hold", rd_pc, 64'd2036);

    // ---- push+pop on empty, then reset mid-capture at count 7
    start = 1'b1;
    tick();
    start = 1'b0;
    pop = 1'b1;
    drive(64'd3000, 32'd0);
    pop = 1'b0;
    chk("t6_pp_count", {59'd0, count}, 64'd1);
    chk("t6_pp_valid", {63'd0, rd_valid}, 64'd0);
    for (int i = 1; i < 7; i++) drive(64'(3000 + 4 * i), 32'd0);
    chk("t6_pre_count", {59'd0, count}, 64'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_count", {59'd0, count}, 64'd0);
    chk("t6_rst_empty", {63'd0, empty}, 64'd1);
    chk("t6_rst_state", {62'd0, state}, 64'd0);
    chk("t6_rst_dropped", {48'd0, dropped}, 64'd0);
    chk("t6_rst_rd_pc", rd_pc, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_trace_fifo.md
Name: cpu_trace_fifo

Overview:
Trace-capture stage that sits directly downstream of the single-cycle cpu. It consumes the per-cycle outputs of the cpu: the counter (PC), instruction, ALUout and memdata. Each clock in which capture is active, it records one sample into a circular FIFO. A host or bench drains the FIFO later through a pop interface. This gives a synthesizable replacement for cycle-by-cycle $display monitoring, including halt detection and overflow accounting.

Parameters:
DEPTH, 16, number of trace entries; must be a power of 2, at least 2.
ADDR_W, 4, log2(DEPTH).
HALT_INSN, 32'hD4400000, instruction encoding that ends capture.

Ports:
clock  input  1  rising-edge clock shared with the cpu
reset  input  1  synchronous, active-high reset
start  input  1  arm capture (pulse)
stop  input  1  end capture (pulse)
pc  input  64  cpu counter output
instruction  input  32  cpu instruction output
alu_out  input  64  cpu ALUout
mem_data  input  64  cpu memdata
pop  input  1  request oldest entry
rd_valid  output  1  rd_* holds a freshly popped entry this cycle
rd_pc  output  64  popped pc
rd_instr  output  32  popped instruction
rd_alu  output  64  popped alu_out
rd_mem  output  64  popped mem_data
count  output  ADDR_W+1  entries held, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
dropped  output  16  samples lost while full; saturates at 16'hFFFF
halted  output  1  capture ended by HALT_INSN
state  output  2  00 IDLE, 01 CAPTURE, 10 DONE

Behaviour:
- One clock domain. Reset is synchronous and active-high, named reset; the clock is named clock.
- Reset values:
  - state=IDLE; write pointer, read pointer and count = 0.
  - empty=1, full=0, rd_valid=0, rd_* = 0, dropped=0, halted=0.
  - Storage array is not reset.
  - Reset mid-capture discards all entries; the next cycle shows count=0.
- FSM:
  - IDLE: start -> CAPTURE. No sample is taken in the start cycle; the first sample is taken on the following edge.
  - CAPTURE: on each edge, sample {pc, instruction, alu_out, mem_data}.
    - stop -> DONE; the stop-cycle sample is not captured.
    - If instruction==HALT_INSN, that sample is captured (subject to full rules), halted is set to 1, and the next state is DONE.
    - If stop and halt occur in the same cycle, stop wins: no capture, halted stays 0.
    - start is ignored while in CAPTURE.
  - DONE: no capture. start -> CAPTURE; this clears dropped and halted but retains FIFO contents.
- Push rules:
  - Not full: the push is accepted and the write pointer increments modulo DEPTH.
  - Full with no pop in the same cycle: the sample is discarded and dropped increments (saturating).
  - Full with a pop in the same cycle: the push is accepted, count stays DEPTH, dropped is unchanged.
- Pop rules:
  - pop && !empty: the oldest entry is read. On the next edge, rd_valid=1 and rd_* equal that entry (latency 1). The read pointer increments modulo DEPTH.
  - pop while empty: ignored; rd_valid=0 next cycle.
  - When rd_valid=0, rd_* hold their previous values.
  - pop is honoured in every state, including IDLE and DONE.
- Empty with simultaneous push and pop: the pop is ignored, the push proceeds, and count becomes 1. No bypass path.
- count updates: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Pointers wrap silently; FIFO order is preserved across the wrap.

Test Plan:
- Reset, pulse start, drive pc=0,4,8,12,16 on 5 edges, then pulse stop -> count=5, state=DONE. Five pops return rd_pc 0,4,8,12,16, each with rd_valid=1 one cycle after its pop.
- Capture 19 samples with pc=0..72 step 4 and no pops -> full=1, count=16, dropped=3; first pop returns rd_pc=0.
- While full, assert pop together with a sample pc=100 -> count stays 16, dropped unchanged. Draining all 16 entries gives last rd_pc=100.
- instruction=HALT_INSN on the 3rd sample -> count=3, halted=1, state=DONE next cycle. Later samples are ignored and count stays 3.
- Capture 12, pop 10, capture 10 (pointers wrap) -> count=12. The drain order is the 2 surviving entries of the first batch, then the 10 new entries, in order.
- pop while empty -> rd_valid=0, count=0. Assert reset during CAPTURE with count=7 -> next cycle count=0, empty=1, state=IDLE, dropped=0.
